io_console: RTL
===============

# io_console

Memory-mapped console and interval-timer peripheral that sits on the responder side of the ZPU core's memory bus, beside the RAM, behind a top-level address decode. It accepts the core's read/write requests, completes each request with a one-cycle done pulse, and buffers console bytes in a FIFO that drains through a valid/ready byte port. An optional down-counting timer drives the core's interrupt request.

## Interface
- FIFO_DEPTH, 16, console FIFO entries; power of two, 2..256
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- i_read  input  1  read request, already qualified by the top-level decode; held until o_done
- i_write  input  1  write request, already qualified by the top-level decode; held until o_done
- i_addr  input  2  word index; the top level connects o_addr[3:2]
- i_data_write  input  32  write data
- o_data_read  output  32  read data; valid in the cycle o_done is high
- o_done  output  1  one-cycle completion pulse
- o_tx_data  output  8  head-of-FIFO byte
- o_tx_valid  output  1  FIFO not empty
- i_tx_ready  input  1  sink accepts o_tx_data when o_tx_valid and i_tx_ready are both high
- o_interrupt  output  1  timer interrupt request, level

## Operation
- Register map (by i_addr):
  - 0 TXDATA: a write pushes i_data_write[7:0]. A read returns the FIFO count, zero-extended.
  - 1 STATUS: read-only. bit0 = empty, bit1 = full, bit2 = timer pending, other bits 0. Writes are accepted and ignored.
  - 2 TLOAD: a write sets the reload value and also loads the counter. A read returns the current counter.
  - 3 TCTRL: bit0 = timer enable, bit1 = interrupt enable. Writing 1 to bit2 clears pending. A read returns {29'b0, pending, ie, en}.
- Request acceptance:
  - A request is accepted in a cycle where (i_read | i_write) is high and o_done is low.
  - If i_read and i_write are both high, the write wins.
- TXDATA write to a full FIFO is not accepted. The request stalls, with o_done held low, until count < FIFO_DEPTH.
- All other accesses are never stalled.
- FIFO pop: happens when o_tx_valid & i_tx_ready. A push and a pop in the same cycle leave the count unchanged.
- Timer:
  - When en = 1, the 32-bit counter decrements every cycle.
  - When the counter is 0 and en = 1, it sets pending and reloads from TLOAD. The period is therefore TLOAD+1 cycles.
  - If a TLOAD write and an expiry occur in the same cycle, the write wins; pending is still set.
  - If a pending clear and an expiry occur in the same cycle, pending stays set.
- o_interrupt = pending & ie.

## Timing
- Reset values:
  - o_done = 0, o_data_read = 0, o_tx_valid = 0, o_tx_data = 0, o_interrupt = 0.
  - FIFO empty, counter = 0, TLOAD = 0, en = ie = pending = 0.
- Latency: the request is accepted at clock edge N; o_done and o_data_read are registered and high during cycle N+1. Latency is 1 cycle.
- o_done is never high for two consecutive cycles. The initiator drops or changes its request in the cycle after o_done.
- Write side effects (push, register update) take effect at the acceptance edge.
- o_tx_data / o_tx_valid are driven from FIFO state registers. A byte pushed at edge N is visible in cycle N+1.
- Reset asserted mid-transaction:
  - The pending request is dropped and no o_done is issued.
  - FIFO contents are lost.
  - The initiator restarts from its own reset.
- Pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide, so full and empty are unambiguous.

## Configuration
- IO_CONSOLE_TIMER_EN
  - Defined: the timer, TLOAD/TCTRL and the interrupt are implemented as described.
  - Not defined: no counter logic. Reads of addresses 2 and 3 return 0, and writes are accepted with o_done but have no effect. STATUS bit2 reads 0, and o_interrupt is tied to 0.

## Test plan
- Reset, then read STATUS → o_done one cycle later; o_data_read = 32'h1 (empty). o_tx_valid = 0.
- i_tx_ready = 1, write TXDATA 32'h41 → o_done at N+1; o_tx_data = 8'h41 with o_tx_valid high in cycle N+1; popped at the next edge.
- i_tx_ready = 0, 17 TXDATA writes with FIFO_DEPTH = 16:
  - Writes 1–16 each complete in 1 cycle, and STATUS reads 32'h2.
  - Write 17 stalls until i_tx_ready is pulsed once, then completes one cycle later.
- Write TLOAD = 4, then TCTRL = 3 → pending and o_interrupt rise 5 cycles after the counter first decrements, then repeat every 5 cycles. Write TCTRL = 7 → o_interrupt drops, then re-asserts at the next expiry.
- Hold i_read high across a completion → exactly one o_done per accepted request, never on consecutive cycles.
- Assert reset during a stalled TXDATA write → o_done never pulses; all outputs return to reset values immediately. With IO_CONSOLE_TIMER_EN undefined, a TCTRL read returns 0 and o_interrupt stays 0.

Source files
------------

// File: rtl/io_console.sv
// rtl/io_console.sv - ZPU memory-bus console FIFO with optional interval timer
// Optional timer, TLOAD/TCTRL and interrupt are built when IO_CONSOLE_TIMER_EN is defined.
module io_console #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_read,
   input  logic        i_write,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_data_write,
   output logic [31:0] o_data_read,
   output logic        o_done,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic        o_interrupt
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          fifo_empty;
   logic          fifo_full;
   logic          tx_stall;
   logic          accept;
   logic          wr_acc;
   logic          push;
   logic          pop;
   logic [31:0]   rd_mux;
   logic          timer_pending;
   logic [31:0]   timer_count;
   logic [31:0]   timer_ctrl;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CW'(FIFO_DEPTH));
   // Only a TXDATA write into a full FIFO holds off; the initiator keeps it asserted.
   assign tx_stall   = i_write && (i_addr == 2'd0) && fifo_full;
   assign accept     = (i_read || i_write) && !o_done && !tx_stall;
   assign wr_acc     = accept && i_write;
   assign push       = wr_acc && (i_addr == 2'd0);
   assign pop        = o_tx_valid && i_tx_ready;

   assign o_tx_valid = !fifo_empty;
   assign o_tx_data  = fifo_empty ? 8'h00 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= i_data_write[7:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef IO_CONSOLE_TIMER_EN
   logic [31:0] counter;
   logic [31:0] reload;
   logic        t_en;
   logic        t_ie;
   logic        pending;
   logic        expire;
   logic        tload_wr;
   logic        tctrl_wr;

   assign tload_wr = wr_acc && (i_addr == 2'd2);
   assign tctrl_wr = wr_acc && (i_addr == 2'd3);
   assign expire   = t_en && (counter == 32'd0);

   // A TLOAD write overrides the reload on expiry; an expiry overrides a pending clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         counter <= '0;
         reload  <= '0;
         t_en    <= 1'b0;
         t_ie    <= 1'b0;
         pending <= 1'b0;
      end else begin
         if (tload_wr) begin
            counter <= i_data_write;
            reload  <= i_data_write;
         end else if (expire) begin
            counter <= reload;
         end else if (t_en) begin
            counter <= counter - 32'd1;
         end
         if (tctrl_wr) begin
            t_en <= i_data_write[0];
            t_ie <= i_data_write[1];
         end
         if (expire) begin
            pending <= 1'b1;
         end else if (tctrl_wr && i_data_write[2]) begin
            pending <= 1'b0;
         end
      end
   end

   assign timer_pending = pending;
   assign timer_count   = counter;
   assign timer_ctrl    = {29'b0, pending, t_ie, t_en};
   assign o_interrupt   = pending && t_ie;
`else
   logic unused_wdata;
   assign unused_wdata  = ^i_data_write[31:8];
   assign timer_pending = 1'b0;
   assign timer_count   = 32'd0;
   assign timer_ctrl    = 32'd0;
   assign o_interrupt   = 1'b0;
`endif

   always_comb begin
      rd_mux = 32'd0;
      case (i_addr)
         2'd0:    rd_mux = 32'(count);
         2'd1:    rd_mux = {29'b0, timer_pending, fifo_full, fifo_empty};
         2'd2:    rd_mux = timer_count;
         default: rd_mux = timer_ctrl;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_done      <= 1'b0;
         o_data_read <= 32'd0;
      end else begin
         o_done <= accept;
         if (accept) begin
            o_data_read <= rd_mux;
         end
      end
   end

endmodule
